// File: rtl/sync_mc_fifo.sv
// sync_mc_fifo: single-clock FIFO with NUM_CH independent queues sharing one write and one read port.
// Per-channel occupancy drives combinational status flags; flush clears one or more channels in a cycle.
module sync_mc_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int NUM_CH     = 4,
    parameter int AF_MARGIN  = 2,
    parameter int AE_MARGIN  = 2,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [CW-1:0]            wr_ch,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [CW-1:0]            rd_ch,
    input  logic [NUM_CH-1:0]        flush,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        empty,
    output logic [NUM_CH-1:0]        almost_full,
    output logic [NUM_CH-1:0]        almost_empty,
    output logic                     overflow,
    output logic                     underflow,
    output logic [NUM_CH*(AW+1)-1:0] count
);
    localparam logic [AW:0] DEPTH_V  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [AW:0] AE_LVL   = (AW+1)'(AE_MARGIN);
    localparam logic [CW:0] NUM_CH_V = (CW+1)'(NUM_CH);

    logic [DATA_WIDTH-1:0] mem_q [NUM_CH][DEPTH];
    logic [AW-1:0]         wr_ptr_q [NUM_CH];
    logic [AW-1:0]         wr_ptr_d [NUM_CH];
    logic [AW-1:0]         rd_ptr_q [NUM_CH];
    logic [AW-1:0]         rd_ptr_d [NUM_CH];
    logic [AW:0]           count_q  [NUM_CH];
    logic [AW:0]           count_d  [NUM_CH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic wr_in_range, rd_in_range;
    logic wr_ok, rd_ok, wr_rej, rd_rej;
    logic wr_hit, rd_hit;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            count[k*(AW+1) +: AW+1] = count_q[k];
            full[k]         = (count_q[k] == DEPTH_V);
            empty[k]        = (count_q[k] == '0);
            almost_full[k]  = (count_q[k] >= AF_LVL);
            almost_empty[k] = (count_q[k] <= AE_LVL);
        end
    end

    // A flushed channel silently drops its request; only full/empty or a bad channel raise an error pulse.
    always_comb begin
        wr_in_range = ({1'b0, wr_ch} < NUM_CH_V);
        rd_in_range = ({1'b0, rd_ch} < NUM_CH_V);
        wr_ok  = wr_en && wr_in_range && !flush[wr_ch] && !full[wr_ch];
        rd_ok  = rd_en && rd_in_range && !flush[rd_ch] && !empty[rd_ch];
        wr_rej = wr_en && (!wr_in_range || (!flush[wr_ch] && full[wr_ch]));
        rd_rej = rd_en && (!rd_in_range || (!flush[rd_ch] && empty[rd_ch]));
    end

    // rd_valid pulses for exactly one cycle, the cycle after an accepted read; rd_data holds otherwise.
    always_comb begin
        wr_hit      = 1'b0;
        rd_hit      = 1'b0;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_ok;
        overflow_d  = wr_rej;
        underflow_d = rd_rej;
        if (rd_ok) begin
            rd_data_d = mem_q[rd_ch][rd_ptr_q[rd_ch]];
        end
        for (int k = 0; k < NUM_CH; k++) begin
            wr_hit      = wr_ok && (wr_ch == CW'(k));
            rd_hit      = rd_ok && (rd_ch == CW'(k));
            wr_ptr_d[k] = wr_ptr_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            count_d[k]  = count_q[k];
            if (flush[k]) begin
                wr_ptr_d[k] = '0;
                rd_ptr_d[k] = '0;
                count_d[k]  = '0;
            end else begin
                if (wr_hit) wr_ptr_d[k] = wr_ptr_q[k] + AW'(1);
                if (rd_hit) rd_ptr_d[k] = rd_ptr_q[k] + AW'(1);
                if (wr_hit && !rd_hit) count_d[k] = count_q[k] + (AW+1)'(1);
                else if (rd_hit && !wr_hit) count_d[k] = count_q[k] - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                count_q[k]  <= '0;
            end
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                count_q[k]  <= count_d[k];
            end
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: an entry is only read after the count says it was written.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem_q[wr_ch][wr_ptr_q[wr_ch]] <= wr_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_sync_mc_fifo.sv
// tb_sync_mc_fifo: directed plus randomized stimulus for sync_mc_fifo, checked against per-channel
// queue models and an expected read-data queue.
module tb_sync_mc_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int NCH   = 4;
  localparam int AW    = 4;
  localparam int AFM   = 2;
  localparam int AEM   = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic                 wr_en = 1'b0;
  logic [1:0]           wr_ch = '0;
  logic [DW-1:0]        wr_data = '0;
  logic                 rd_en = 1'b0;
  logic [1:0]           rd_ch = '0;
  logic [NCH-1:0]       flush = '0;
  logic [DW-1:0]        rd_data;
  logic                 rd_valid;
  logic [NCH-1:0]       full, empty, almost_full, almost_empty;
  logic                 overflow, underflow;
  logic [NCH*(AW+1)-1:0] count;

  sync_mc_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH), .AF_MARGIN(AFM), .AE_MARGIN(AEM)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .rd_en(rd_en), .rd_ch(rd_ch), .flush(flush),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .count(count)
  );

  // reference model
  logic [DW-1:0] ch_q [NCH][$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd;
  logic          exp_vld, exp_ovf, exp_unf;
  int            checks = 0;
  int            failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] e_full, e_empty, e_af, e_ae;
    for (int k = 0; k < NCH; k++) begin
      int n;
      n = ch_q[k].size();
      check_eq($sformatf("count%0d", k), 32'(count[k*(AW+1) +: AW+1]), 32'(n));
      e_full[k]  = (n == DEPTH);
      e_empty[k] = (n == 0);
      e_af[k]    = (n >= DEPTH - AFM);
      e_ae[k]    = (n <= AEM);
    end
    check_eq("full", 32'(full), 32'(e_full));
    check_eq("empty", 32'(empty), 32'(e_empty));
    check_eq("almost_full", 32'(almost_full), 32'(e_af));
    check_eq("almost_empty", 32'(almost_empty), 32'(e_ae));
    check_eq("rd_valid", 32'(rd_valid), 32'(exp_vld));
    check_eq("overflow", 32'(overflow), 32'(exp_ovf));
    check_eq("underflow", 32'(underflow), 32'(exp_unf));
    if (exp_vld) begin
      if (exp_q.size() > 0) last_rd = exp_q.pop_front();
      else check_eq("exp_q_empty", 32'(1), 32'(0));
    end
    check_eq("rd_data", 32'(rd_data), 32'(last_rd));
  endtask

  // driver: one clock of stimulus, model update from pre-edge state, then check after the edge
  task automatic step(input logic we, input logic [1:0] wc, input logic [DW-1:0] wd,
                      input logic re, input logic [1:0] rc, input logic [NCH-1:0] fl,
                      input logic rs);
    logic w_ok, r_ok;
    @(negedge clk);
    rst = rs; wr_en = we; wr_ch = wc; wr_data = wd; rd_en = re; rd_ch = rc; flush = fl;
    if (rs) begin
      for (int k = 0; k < NCH; k++) ch_q[k].delete();
      exp_q.delete();
      exp_vld = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
      last_rd = '0;
    end else begin
      r_ok    = re && !fl[rc] && (ch_q[rc].size() > 0);
      w_ok    = we && !fl[wc] && (ch_q[wc].size() < DEPTH);
      exp_unf = re && !fl[rc] && (ch_q[rc].size() == 0);
      exp_ovf = we && !fl[wc] && (ch_q[wc].size() == DEPTH);
      exp_vld = r_ok;
      if (r_ok) exp_q.push_back(ch_q[rc].pop_front());
      if (w_ok) ch_q[wc].push_back(wd);
      for (int k = 0; k < NCH; k++) if (fl[k]) ch_q[k].delete();
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic wr(input logic [1:0] c, input logic [DW-1:0] d);
    step(1'b1, c, d, 1'b0, 2'd0, '0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] c);
    step(1'b0, 2'd0, '0, 1'b1, c, '0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, '0, 1'b0, 2'd0, '0, 1'b0);
  endtask

  initial begin
    last_rd = '0; exp_vld = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;

    // reset then idle
    step(1'b0, 2'd0, '0, 1'b0, 2'd0, '0, 1'b1);
    step(1'b0, 2'd0, '0, 1'b0, 2'd0, '0, 1'b1);
    idle();

    // fill and drain ch2 in order
    for (int i = 0; i < 16; i++) wr(2'd2, 8'(i));
    for (int i = 0; i < 16; i++) rd(2'd2);
    idle();

    // ch1 full, then simultaneous write+read on ch1
    for (int i = 0; i < 16; i++) wr(2'd1, 8'(8'h10 + i));
    step(1'b1, 2'd1, 8'hEE, 1'b1, 2'd1, '0, 1'b0);
    idle();
    // empty ch0: read rejected, write accepted
    step(1'b1, 2'd0, 8'h77, 1'b1, 2'd0, '0, 1'b0);
    idle();
    step(1'b0, 2'd0, '0, 1'b0, 2'd0, 4'b1111, 1'b0);

    // interleave ch0/ch3 writes with reads, wrapping past DEPTH
    for (int i = 0; i < 40; i++) begin
      logic [1:0] wc, rc;
      wc = (i % 2 == 0) ? 2'd0 : 2'd3;
      rc = (i % 4 < 2) ? 2'd3 : 2'd0;
      step(1'b1, wc, (wc == 2'd0) ? 8'(8'hA0 + i / 2) : 8'(8'h30 + i / 2),
           (i > 3), rc, '0, 1'b0);
    end
    for (int i = 0; i < 24; i++) rd((i % 2 == 0) ? 2'd0 : 2'd3);
    step(1'b0, 2'd0, '0, 1'b0, 2'd0, 4'b1111, 1'b0);

    // flush ch3 with same-cycle write and read on it
    for (int i = 0; i < 5; i++) wr(2'd3, 8'(8'hC0 + i));
    wr(2'd1, 8'h11);
    step(1'b1, 2'd3, 8'h99, 1'b1, 2'd3, 4'b1000, 1'b0);
    wr(2'd3, 8'h55);
    rd(2'd3);
    idle();
    rd(2'd1);

    // reset with a read in flight on ch0
    for (int i = 0; i < 8; i++) wr(2'd0, 8'(8'h80 + i));
    rd(2'd0);
    step(1'b0, 2'd0, '0, 1'b1, 2'd0, '0, 1'b1);
    idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [NCH-1:0] fl;
      fl = ($urandom_range(0, 31) == 0) ? NCH'($urandom_range(1, 15)) : '0;
      step(1'($urandom_range(0, 99) < 55), 2'($urandom_range(0, 3)), 8'($urandom),
           1'($urandom_range(0, 99) < 45), 2'($urandom_range(0, 3)), fl,
           1'($urandom_range(0, 499) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
